// File: rtl/timer_bcd_mod.sv
// Two-digit BCD interval timer (modulus 2..100, up/down, clear, wrap pulse, 7-segment drive).
// Optional pause debounce filter enabled by defining TIMER_PAUSE_DEBOUNCE_EN.
module timer_bcd_mod #(
    parameter int unsigned CLK_DIV      = 12000000,
    parameter int unsigned MODULO       = 60,
    parameter int unsigned DEBOUNCE_CYC = 240000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       pause,
    input  logic       clr,
    input  logic       down,
    output logic       running,
    output logic       wrap,
    output logic [7:0] count_bcd,
    output logic [8:0] segment_led_1,
    output logic [8:0] segment_led_2
);

    localparam int unsigned      PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
    localparam logic [3:0]       MAX_TENS = 4'((MODULO - 1) / 10);
    localparam logic [3:0]       MAX_ONES = 4'((MODULO - 1) % 10);
    localparam logic [8:0]       SEG_RST  = 9'h03F;

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("timer_bcd_mod: CLK_DIV must be at least 1");
    end
    if (MODULO < 2 || MODULO > 100) begin : g_bad_modulo
        $error("timer_bcd_mod: MODULO must lie in 2..100");
    end
    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("timer_bcd_mod: DEBOUNCE_CYC must be at least 1");
    end

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             prev_q, prev_d, run_q, run_d, wrap_q, wrap_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [3:0]       tens_q, tens_d, ones_q, ones_d;
    logic [8:0]       seg1_q, seg1_d, seg2_q, seg2_d;
    logic             pause_lvl;
    logic             tick;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

`ifdef TIMER_PAUSE_DEBOUNCE_EN
    localparam int unsigned      DEB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYC - 1);

    logic             filt_q, filt_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // Filtered level follows the synchronized input only after a full stable run.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                filt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            filt_q    <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            filt_q    <= filt_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign pause_lvl = filt_q;
`else
    assign pause_lvl = sync2_q;
`endif

    assign tick = run_q && (presc_q == PRE_MAX);

    always_comb begin
        sync1_d = pause;
        sync2_d = sync1_q;
        prev_d  = pause_lvl;
        run_d   = run_q;
        wrap_d  = 1'b0;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        seg1_d  = {2'b00, seg7(tens_q)};
        seg2_d  = {2'b00, seg7(ones_q)};

        if (pause_lvl && !prev_q) begin
            run_d = ~run_q;
        end

        // Clear beats a same-cycle tick; the prescaler only advances while running.
        if (clr) begin
            presc_d = '0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else if (tick) begin
            presc_d = '0;
            if (!down) begin
                if (tens_q == MAX_TENS && ones_q == MAX_ONES) begin
                    tens_d = 4'd0;
                    ones_d = 4'd0;
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (tens_q == 4'd0 && ones_q == 4'd0) begin
                    tens_d = MAX_TENS;
                    ones_d = MAX_ONES;
                    wrap_d = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end else if (run_q) begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            run_q   <= 1'b1;
            wrap_q  <= 1'b0;
            presc_q <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            seg1_q  <= SEG_RST;
            seg2_q  <= SEG_RST;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            run_q   <= run_d;
            wrap_q  <= wrap_d;
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            seg1_q  <= seg1_d;
            seg2_q  <= seg2_d;
        end
    end

    assign running       = run_q;
    assign wrap          = wrap_q;
    assign count_bcd     = {tens_q, ones_q};
    assign segment_led_1 = seg1_q;
    assign segment_led_2 = seg2_q;

endmodule

// File: tb/tb_timer_bcd_mod.sv
// Scoreboard bench for timer_bcd_mod: three instances (mod 60 / 100 / 2) share one stimulus stream.
module tb_timer_bcd_mod;

    localparam int DEB = 8;
    localparam int DIV  [3] = '{4, 1, 1};
    localparam int MODS [3] = '{60, 100, 2};
`ifdef TIMER_PAUSE_DEBOUNCE_EN
    localparam int        PAUSE_LAT = 3 + DEB;
    localparam int        PULSE_W   = 20;
    localparam logic [7:0] HELD_V   = 8'h09;
    localparam logic [7:0] RESUME_V = 8'h0A;
    localparam logic      GLITCH_RUN = 1'b1;
`else
    localparam int        PAUSE_LAT = 3;
    localparam int        PULSE_W   = 2;
    localparam logic [7:0] HELD_V   = 8'h07;
    localparam logic [7:0] RESUME_V = 8'h08;
    localparam logic      GLITCH_RUN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] cnt;
        logic       wrap;
        logic       run;
        logic [8:0] seg1;
        logic [8:0] seg2;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pause, clr, down;
    logic       run_o  [3];
    logic       wrap_o [3];
    logic [7:0] cnt_o  [3];
    logic [8:0] s1_o   [3];
    logic [8:0] s2_o   [3];

    timer_bcd_mod #(.CLK_DIV(4), .MODULO(60), .DEBOUNCE_CYC(DEB)) u_m60 (
        .clk_in(clk), .rst_n_in(rst_n), .pause(pause), .clr(clr), .down(down),
        .running(run_o[0]), .wrap(wrap_o[0]), .count_bcd(cnt_o[0]),
        .segment_led_1(s1_o[0]), .segment_led_2(s2_o[0]));
    timer_bcd_mod #(.CLK_DIV(1), .MODULO(100), .DEBOUNCE_CYC(DEB)) u_m100 (
        .clk_in(clk), .rst_n_in(rst_n), .pause(pause), .clr(clr), .down(down),
        .running(run_o[1]), .wrap(wrap_o[1]), .count_bcd(cnt_o[1]),
        .segment_led_1(s1_o[1]), .segment_led_2(s2_o[1]));
    timer_bcd_mod #(.CLK_DIV(1), .MODULO(2), .DEBOUNCE_CYC(DEB)) u_m2 (
        .clk_in(clk), .rst_n_in(rst_n), .pause(pause), .clr(clr), .down(down),
        .running(run_o[2]), .wrap(wrap_o[2]), .count_bcd(cnt_o[2]),
        .segment_led_1(s1_o[2]), .segment_led_2(s2_o[2]));

    int n_checks = 0;
    int n_errors = 0;
    int wraps0   = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Reference model in plain integers; one expected record per instance per clock.
    int         m_cnt [3];
    int         m_presc [3];
    logic       m_wrap [3];
    logic [8:0] m_seg1 [3];
    logic [8:0] m_seg2 [3];
    logic       m_run, m_s1, m_s2, m_prev, m_filt;
    int         m_dcnt;

    always @(posedge clk) begin : model
        logic lvl;
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_presc[i] = 0; m_wrap[i] = 1'b0;
                m_seg1[i] = 9'h03F; m_seg2[i] = 9'h03F;
            end
            m_run = 1'b1; m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0; m_filt = 1'b0; m_dcnt = 0;
        end else begin
`ifdef TIMER_PAUSE_DEBOUNCE_EN
            lvl = m_filt;
            if (m_s2 != m_filt) begin
                if (m_dcnt == DEB - 1) begin m_filt = m_s2; m_dcnt = 0; end
                else m_dcnt++;
            end else m_dcnt = 0;
`else
            lvl = m_s2;
`endif
            for (int i = 0; i < 3; i++) begin
                m_seg1[i] = {2'b00, seg7(m_cnt[i] / 10)};
                m_seg2[i] = {2'b00, seg7(m_cnt[i] % 10)};
                m_wrap[i] = 1'b0;
                if (clr) begin
                    m_cnt[i] = 0; m_presc[i] = 0;
                end else if (m_run) begin
                    if (m_presc[i] == DIV[i] - 1) begin
                        m_presc[i] = 0;
                        if (!down) begin
                            if (m_cnt[i] == MODS[i] - 1) begin m_cnt[i] = 0; m_wrap[i] = 1'b1; end
                            else m_cnt[i]++;
                        end else begin
                            if (m_cnt[i] == 0) begin m_cnt[i] = MODS[i] - 1; m_wrap[i] = 1'b1; end
                            else m_cnt[i]--;
                        end
                    end else m_presc[i]++;
                end
            end
            if (lvl && !m_prev) m_run = !m_run;
            m_prev = lvl; m_s2 = m_s1; m_s1 = pause;
        end
        for (int i = 0; i < 3; i++) begin
            e.cnt = to_bcd(m_cnt[i]); e.wrap = m_wrap[i]; e.run = m_run;
            e.seg1 = m_seg1[i]; e.seg2 = m_seg2[i];
            sb_q.push_back(e);
        end
    end

    // One clock: let the edge happen, then compare every instance on the falling edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("cnt%0d", i),  32'(cnt_o[i]),  32'(e.cnt));
                check($sformatf("wrap%0d", i), 32'(wrap_o[i]), 32'(e.wrap));
                check($sformatf("run%0d", i),  32'(run_o[i]),  32'(e.run));
                check($sformatf("seg1_%0d", i), 32'(s1_o[i]),  32'(e.seg1));
                check($sformatf("seg2_%0d", i), 32'(s2_o[i]),  32'(e.seg2));
            end
        end
        if (wrap_o[0]) wraps0++;
    endtask

    initial begin : stim
        int   n;
        logic [7:0] prev_cnt;
        logic r0;
        rst_n = 1'b0; pause = 1'b0; clr = 1'b0; down = 1'b0;
        repeat (3) step();
        check("rst_cnt", 32'(cnt_o[0]), 32'h00);
        check("rst_run", 32'(run_o[0]), 32'd1);
        check("rst_seg", 32'(s2_o[0]), 32'h03F);

        // Free run for one full modulus-60 revolution.
        rst_n = 1'b1; wraps0 = 0; prev_cnt = 8'h00;
        for (int c = 0; c < 240; c++) begin
            step();
            if (prev_cnt[3:0] == 4'd9) check("seg2_nine", 32'(s2_o[0]), 32'h06F);
            prev_cnt = cnt_o[0];
        end
        check("wrap_once", 32'(wraps0), 32'd1);
        check("cnt_240", 32'(cnt_o[0]), 32'h00);

        // Pause at 07, hold 1000 cycles, then resume.
        n = 0;
        while (cnt_o[0] != 8'h07 && n < 200) begin step(); n++; end
        check("wait07_timeout", 32'(n < 200), 32'd1);
        pause = 1'b1; repeat (PULSE_W) step(); pause = 1'b0;
        repeat (1000) step();
        check("held_cnt", 32'(cnt_o[0]), 32'(HELD_V));
        check("held_run", 32'(run_o[0]), 32'd0);
        pause = 1'b1; n = 0;
        while (run_o[0] != 1'b1 && n < 40) begin step(); n++; end
        check("resume_timeout", 32'(n < 40), 32'd1);
        step();
        check("resume_cnt", 32'(cnt_o[0]), 32'(RESUME_V));
        repeat (PULSE_W) step();
        pause = 1'b0; repeat (30) step();

        // Clear coinciding with a tick at 23.
        n = 0;
        while (!(cnt_o[0] == 8'h23 && m_presc[0] == DIV[0] - 1) && n < 400) begin step(); n++; end
        check("wait23_timeout", 32'(n < 400), 32'd1);
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_cnt", 32'(cnt_o[0]), 32'h00);
        check("clr_wrap", 32'(wrap_o[0]), 32'd0);
        check("clr_run", 32'(run_o[0]), 32'd1);
        repeat (3) step();
        check("clr_phase0", 32'(cnt_o[0]), 32'h00);
        step();
        check("clr_phase1", 32'(cnt_o[0]), 32'h01);

        // Mid-operation reset, then count down from reset.
        rst_n = 1'b0; down = 1'b1; step();
        check("mid_rst_cnt", 32'(cnt_o[0]), 32'h00);
        check("mid_rst_run", 32'(run_o[0]), 32'd1);
        step(); rst_n = 1'b1;
        step();
        check("m100_down", 32'(cnt_o[1]), 32'h99);
        check("m100_wrap", 32'(wrap_o[1]), 32'd1);
        check("m2_down", 32'(cnt_o[2]), 32'h01);
        check("m2_wrap", 32'(wrap_o[2]), 32'd1);
        repeat (3) step();
        check("down_first", 32'(cnt_o[0]), 32'h59);
        check("down_wrap", 32'(wrap_o[0]), 32'd1);
        n = 0;
        while (cnt_o[0] != 8'h55 && n < 100) begin step(); n++; end
        check("wait55_timeout", 32'(n < 100), 32'd1);
        down = 1'b0; repeat (4) step();
        check("dir_switch", 32'(cnt_o[0]), 32'h56);

        // Short glitch, then a long press with measured latency.
        pause = 1'b1; repeat (5) step(); pause = 1'b0; repeat (20) step();
        check("glitch_run", 32'(run_o[0]), 32'(GLITCH_RUN));
        r0 = run_o[0]; pause = 1'b1; n = 0;
        while (run_o[0] == r0 && n < 60) begin step(); n++; end
        check("press_lat", 32'(n), 32'(PAUSE_LAT));
        if (n < 20) repeat (20 - n) step();
        pause = 1'b0; repeat (30) step();

        // Reset asserted in the middle of a press.
        pause = 1'b1; repeat (6) step();
        rst_n = 1'b0; step();
        check("rst_press_cnt", 32'(cnt_o[0]), 32'h00);
        check("rst_press_run", 32'(run_o[0]), 32'd1);
        rst_n = 1'b1; pause = 1'b0; repeat (20) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
